fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a `fifo` instance among `NUM_REQ` producers (e.g. core store path, debug unit, DMA into the UART TX queue). Each producer presents packets of one or more words over a valid/ready/last handshake. A grant is held for a whole packet so words from different producers never interleave. Accepted words pass through one output register that drives the FIFO write port and honours `o_full` back-pressure.

## Interface
- `NUM_REQ`, 4: number of requesters, 1..16.
- `DATA_WIDTH`, 32: word width; must equal the attached fifo's `DATA_WIDTH`.
- `i_clk` in 1: single clock, all logic rising-edge.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_req_valid` in `NUM_REQ`: per-requester word valid.
- `i_req_data` in `NUM_REQ*DATA_WIDTH`: packed words; requester k uses bits `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `i_req_last` in `NUM_REQ`: current word ends the packet.
- `o_req_ready` out `NUM_REQ`: one-hot or zero; a word transfers when valid&ready.
- `o_fifo_write_en` out 1: connects to fifo `i_write_en`.
- `o_fifo_data` out `DATA_WIDTH`: connects to fifo `i_data`.
- `i_fifo_full` in 1: from fifo `o_full`.
- `o_grant_id` out `$clog2(NUM_REQ)` (min 1): current owner, valid while `o_busy`.
- `o_busy` out 1: FSM in LOCKED.

## Operation
- FSM states: IDLE, LOCKED.
- IDLE: if any `i_req_valid`, select the first valid requester searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`; register it into `grant_id`/`last_grant`; next state LOCKED. No ready is asserted in IDLE.
- LOCKED: `o_req_ready[grant_id] = !out_valid || !i_fifo_full`; all other readies 0.
- On a transfer: output register loads the data and `out_valid` becomes 1. If `i_req_last` is also 1, next state is IDLE.
- Drain: `o_fifo_write_en = out_valid`. The word retires on a cycle where `out_valid && !i_fifo_full`. `out_valid` clears on retire unless a new word loads in the same cycle.
- Valid drops mid-packet: the grant is held. The arbiter waits indefinitely, with no timeout.
- Fairness: after the owner's packet ends, the owner has lowest priority in the next IDLE search.
- `NUM_REQ=1`: degenerates to a packetised pass-through with the same timing.
- Reset: state IDLE, `grant_id=0`, `last_grant=NUM_REQ-1` (so requester 0 wins first), `out_valid=0`.
- Reset outputs: `o_fifo_write_en=0`, `o_req_ready=0`, `o_busy=0`, `o_grant_id=0`, `o_fifo_data=0`.
- Reset asserted mid-packet: state is discarded immediately, including any word held in the output register. The requester restarts its packet after reset.

## Timing
- Arbitration: 1 cycle. Valid seen in IDLE at edge N puts `o_busy` high after edge N. Ready can go high in the cycle between N and N+1.
- Word latency: transfer at edge M puts `o_fifo_write_en` high after M; the FIFO writes at edge M+1 if not full.
- Throughput: 1 word/cycle while `i_fifo_full=0`. Each packet boundary costs one IDLE bubble cycle.
- Full: a held word keeps `o_fifo_write_en` and `o_fifo_data` stable until `i_fifo_full` is 0. Ready stays 0 meanwhile, so no word is lost or duplicated.
- Load and drain can occur on the same edge, so back-to-back words need no gap.
- `o_req_ready` is combinational from `i_fifo_full` and registered state only. There is no path from `i_req_valid` to ready.

## Structure
- Package `fifo_arb_pkg`: typedef enum `arb_state_t {ARB_IDLE, ARB_LOCKED}`, and the function `grant_w(n)` returning `max(1,$clog2(n))`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: `found` and `idx`.
  - Implemented via a double-width rotated priority encoder.
- Top level holds the FSM, grant registers and the output register.

## Test plan
- Single requester 1, 3-word packet 0xA,0xB,0xC (last on 0xC), FIFO never full:
  - `o_busy` goes high 1 cycle after valid.
  - Writes 0xA,0xB,0xC on consecutive cycles.
  - Back to IDLE after the last transfer.
- All 4 requesters valid continuously with 1-word packets: grants go 0,1,2,3,0 and each requester gets exactly 1 word per 2 cycles of round.
- Requester 2 sends a 4-word packet while requester 0 is valid:
  - 0 is not granted until 2's last word is accepted.
  - FIFO contents show no interleaving.
- `i_fifo_full` held high for 5 cycles mid-packet:
  - `o_fifo_write_en` and the data are held stable.
  - Ready stays 0.
  - Exactly 4 words are written once full drops, with no duplicate or loss.
- Owner drops valid for 3 cycles mid-packet: grant is held, others stay unready, and the packet completes in order.
- `i_rst_n` pulsed low mid-packet with a word held: all outputs go to reset values asynchronously, and the next grant goes to requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above
// last_grant+1, wrapping modulo NUM_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               found,
  output logic [GW-1:0]      idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   base;

  // Rotate the doubled vector so the search start lands on bit 0, then take the lowest set bit.
  always_comb begin
    base  = (int'(last_grant) + 1) % NUM_REQ;
    dbl   = {req, req};
    rot   = NUM_REQ'(dbl >> base);
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        idx   = GW'((base + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among
// NUM_REQ producers, with a single output register honouring FIFO full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]              i_req_last,
  output logic [NUM_REQ-1:0]              o_req_ready,
  output logic                            o_fifo_write_en,
  output logic [DATA_WIDTH-1:0]           o_fifo_data,
  input  logic                            i_fifo_full,
  output logic [grant_w(NUM_REQ)-1:0]     o_grant_id,
  output logic                            o_busy
);

  localparam int GW = grant_w(NUM_REQ);

  arb_state_t              state;
  logic [GW-1:0]           grant_id;
  logic [GW-1:0]           last_grant;
  logic                    pick_found;
  logic [GW-1:0]           pick_idx;
  logic                    xfer;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    out_vld_p1;
  logic [DATA_WIDTH-1:0]   out_data_p1;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_pick (
    .req        (i_req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // Ready only for the owner, only when the output slot is free or draining this cycle.
  always_comb begin
    o_req_ready = '0;
    if (state == ARB_LOCKED && (!out_vld_p1 || !i_fifo_full)) begin
      o_req_ready = NUM_REQ'(1) << grant_id;
    end
  end

  assign xfer     = |(i_req_valid & o_req_ready);
  assign sel_last = |(i_req_last & o_req_ready);
  assign sel_data = DATA_WIDTH'(i_req_data >> (int'(grant_id) * DATA_WIDTH));

  // Arbitration FSM: pick in IDLE, hold the grant until the owner's last word is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            state      <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (xfer && sel_last) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Stage p1: output register; load on transfer, otherwise clear once the FIFO takes the word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_p1  <= 1'b0;
      out_data_p1 <= '0;
    end else if (xfer) begin
      out_vld_p1  <= 1'b1;
      out_data_p1 <= sel_data;
    end else if (out_vld_p1 && !i_fifo_full) begin
      out_vld_p1  <= 1'b0;
    end
  end

  assign o_fifo_write_en = out_vld_p1;
  assign o_fifo_data     = out_data_p1;
  assign o_grant_id      = grant_id;
  assign o_busy          = (state == ARB_LOCKED);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: queued packet sources, a FIFO
// capture model, and hand-computed expected write sequences.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_wen;
  logic [DW-1:0]     fifo_data;
  logic              fifo_full;
  logic [1:0]        grant_id;
  logic              busy;

  word_t             srcq [N][$];
  logic [N-1:0]      hold;
  logic [DW-1:0]     fifo_d [$];
  int                fifo_c [$];
  int                cyc;
  int                n_chk;
  int                n_err;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .o_fifo_write_en (fifo_wen),
    .o_fifo_data     (fifo_data),
    .i_fifo_full     (fifo_full),
    .o_grant_id      (grant_id),
    .o_busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input logic l);
    word_t w;
    w.d = d;
    w.l = l;
    srcq[k].push_back(w);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int k = 0; k < N; k++) if (srcq[k].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((pending() || busy || fifo_wen) && n < 300) begin
      tick(1);
      n++;
    end
    check("drain_timeout", 64'(n < 300), 64'd1);
  endtask

  task automatic clear_log();
    fifo_d.delete();
    fifo_c.delete();
  endtask

  task automatic check_log(input string tag, input logic [DW-1:0] exp [$]);
    check({tag, "_count"}, 64'(fifo_d.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < fifo_d.size(); i++)
      check(tag, 64'(fifo_d[i]), 64'(exp[i]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) srcq[k].delete();
    hold      = '0;
    fifo_full = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    clear_log();
  endtask

  // Source driver and FIFO capture: sample at negedge, apply just after the rising edge.
  initial begin
    logic [N-1:0]  xf;
    logic          wr;
    logic [DW-1:0] wd;
    cyc = 0;
    forever begin
      @(negedge clk);
      xf = req_valid & req_ready;
      wr = fifo_wen && !fifo_full && rst_n;
      wd = fifo_data;
      @(posedge clk);
      cyc++;
      #1;
      if (wr) begin
        fifo_d.push_back(wd);
        fifo_c.push_back(cyc);
      end
      for (int k = 0; k < N; k++) begin
        if (xf[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        if (srcq[k].size() > 0 && !hold[k]) begin
          req_valid[k]           = 1'b1;
          req_data[k*DW +: DW]   = srcq[k][0].d;
          req_last[k]            = srcq[k][0].l;
        end else begin
          req_valid[k] = 1'b0;
          req_last[k]  = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] exp [$];
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    hold      = '0;

    // Reset state
    tick(2);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_wen",   64'(fifo_wen),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_grant", 64'(grant_id),  64'd0);
    check("rst_data",  64'(fifo_data), 64'd0);
    rst_n = 1'b1;
    tick(1);
    clear_log();

    // Single requester 1, three-word packet
    push(1, 32'hA, 1'b0);
    push(1, 32'hB, 1'b0);
    push(1, 32'hC, 1'b1);
    tick(1);
    check("t1_busy_before", 64'(busy),      64'd0);
    check("t1_ready_idle",  64'(req_ready), 64'd0);
    tick(1);
    check("t1_busy_after",  64'(busy),      64'd1);
    check("t1_grant",       64'(grant_id),  64'd1);
    check("t1_ready",       64'(req_ready), 64'b0010);
    wait_idle();
    exp = '{32'hA, 32'hB, 32'hC};
    check_log("t1_data", exp);
    if (fifo_c.size() == 3) begin
      check("t1_gap0", 64'(fifo_c[1] - fifo_c[0]), 64'd1);
      check("t1_gap1", 64'(fifo_c[2] - fifo_c[1]), 64'd1);
    end
    check("t1_idle", 64'(busy), 64'd0);

    // All four requesters, one-word packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) push(k, DW'(k * 16 + r), 1'b1);
    wait_idle();
    exp = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h01, 32'h11, 32'h21, 32'h31};
    check_log("t2_order", exp);
    for (int i = 1; i < fifo_c.size(); i++)
      check("t2_gap", 64'(fifo_c[i] - fifo_c[i-1]), 64'd2);

    // Requester 2 packet while requester 0 waits
    clear_log();
    push(2, 32'h20, 1'b0);
    push(2, 32'h21, 1'b0);
    push(2, 32'h22, 1'b0);
    push(2, 32'h23, 1'b1);
    tick(2);
    push(0, 32'h0E, 1'b1);
    tick(1);
    check("t3_grant",  64'(grant_id), 64'd2);
    check("t3_r0_off", 64'(req_ready[0]), 64'd0);
    wait_idle();
    exp = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h0E};
    check_log("t3_order", exp);

    // FIFO full for five cycles mid-packet
    clear_log();
    for (int i = 0; i < 5; i++) push(1, DW'(32'h10 + i), (i == 4));
    tick(4);
    fifo_full = 1'b1;
    #1;
    check("t4_ready_full", 64'(req_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t4_hold", 64'({req_ready, fifo_wen, fifo_data}), 64'({4'b0, 1'b1, 32'h11}));
    end
    check("t4_pre_count", 64'(fifo_d.size()), 64'd1);
    fifo_full = 1'b0;
    wait_idle();
    check("t4_post_count", 64'(fifo_d.size() - 1), 64'd4);
    exp = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14};
    check_log("t4_data", exp);

    // Owner drops valid for three cycles
    clear_log();
    for (int i = 0; i < 4; i++) push(3, DW'(32'h30 + i), (i == 3));
    push(0, 32'h0F, 1'b1);
    tick(2);
    check("t5_grant", 64'(grant_id), 64'd3);
    hold[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("t5_held", 64'({busy, grant_id, req_ready[2:0]}), 64'({1'b1, 2'd3, 3'b000}));
    end
    hold[3] = 1'b0;
    wait_idle();
    exp = '{32'h30, 32'h31, 32'h32, 32'h33, 32'h0F};
    check_log("t5_order", exp);

    // Asynchronous reset mid-packet with a held word
    clear_log();
    push(2, 32'h2A, 1'b0);
    push(2, 32'h2B, 1'b0);
    push(2, 32'h2C, 1'b1);
    tick(3);
    fifo_full = 1'b1;
    tick(1);
    check("t6_held_wen", 64'(fifo_wen), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 64'({req_ready, fifo_wen, busy, grant_id, fifo_data}), 64'd0);
    for (int k = 0; k < N; k++) srcq[k].delete();
    fifo_full = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clear_log();
    push(2, 32'h2A, 1'b1);
    push(0, 32'h0A, 1'b1);
    tick(2);
    check("t6_first_grant", 64'({busy, grant_id}), 64'({1'b1, 2'd0}));
    wait_idle();
    exp = '{32'h0A, 32'h2A};
    check_log("t6_order", exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
